// File: rtl/quadrature_pkg.sv
// quadrature_pkg: shared step encoding, counter widths and the {B,A} transition decoder
// for the quadrature decoder array.
package quadrature_pkg;

   localparam int ERROR_COUNT_WIDTH = 8;

   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_INC,
      STEP_DEC,
      STEP_ERR
   } step_t;

   // Forward Gray order is 00 -> 01 -> 11 -> 10 -> 00; a two-bit change is illegal.
   function automatic step_t decodeTransition(input logic [1:0] prevBA, input logic [1:0] currBA);
      step_t result;
      result = STEP_NONE;
      case ({prevBA, currBA})
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: result = STEP_INC;
         4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: result = STEP_DEC;
         4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: result = STEP_ERR;
         default:                                result = STEP_NONE;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/quadrature_channel.sv
// quadrature_channel: one encoder channel -- synchronizer, majority filter, decoder,
// delta/error accumulators, position counter and index capture (QUADRATURE_INDEX_EN).
module quadrature_channel
   import quadrature_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int FILTER_DEPTH = 3
) (
   input  logic                         i_clk,
   input  logic                         i_rstN,
   input  logic                         i_latch,
   input  logic                         i_encA,
   input  logic                         i_encB,
   input  logic                         i_encZ,
   output logic                         o_stepInc,
   output logic                         o_stepDec,
   output logic [DATA_WIDTH-1:0]        o_delta,
   output logic [ERROR_COUNT_WIDTH-1:0] o_errorCount,
   output logic [DATA_WIDTH-1:0]        o_position,
   output logic [DATA_WIDTH-1:0]        o_indexPosition,
   output logic                         o_indexFlag
);

`ifdef QUADRATURE_INDEX_EN
   localparam int NUM_LINES = 3;
`else
   localparam int NUM_LINES = 2;
`endif
   localparam int HIST_DEPTH    = FILTER_DEPTH - 1;
   localparam int WARMUP_CYCLES = 2 + FILTER_DEPTH;
   localparam int WARM_W        = $clog2(WARMUP_CYCLES + 1);

   localparam logic [WARM_W-1:0]            WARM_LAST = WARM_W'(WARMUP_CYCLES);
   localparam logic [WARM_W-1:0]            WARM_ONE  = WARM_W'(1);
   localparam logic [DATA_WIDTH-1:0]        ONE       = DATA_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0]        MINUS_ONE = '1;
   localparam logic [DATA_WIDTH-1:0]        SAT_MAX   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0]        SAT_MIN   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [ERROR_COUNT_WIDTH-1:0] ERR_ONE   = ERROR_COUNT_WIDTH'(1);
   localparam logic [ERROR_COUNT_WIDTH-1:0] ERR_MAX   = '1;

   logic [NUM_LINES-1:0]                 w_raw;
   logic [NUM_LINES-1:0]                 r_sync1;
   logic [NUM_LINES-1:0]                 r_sync2;
   logic [NUM_LINES-1:0][HIST_DEPTH-1:0] r_hist;
   logic [NUM_LINES-1:0]                 w_filt;

   logic [WARM_W-1:0]            r_warmCount;
   logic                         w_warmDone;
   logic [1:0]                   r_prevBA;
   logic [1:0]                   w_currBA;
   step_t                        w_step;
   logic                         r_stepInc;
   logic                         r_stepDec;
   logic                         w_isInc;
   logic                         w_isDec;
   logic                         w_isErr;
   logic [DATA_WIDTH-1:0]        r_acc;
   logic [DATA_WIDTH-1:0]        w_accNext;
   logic [DATA_WIDTH-1:0]        r_delta;
   logic [DATA_WIDTH-1:0]        r_position;
   logic [DATA_WIDTH-1:0]        w_posNext;
   logic [ERROR_COUNT_WIDTH-1:0] r_errAcc;
   logic [ERROR_COUNT_WIDTH-1:0] w_errNext;
   logic [ERROR_COUNT_WIDTH-1:0] r_errCount;

   function automatic int countOnes(input logic [FILTER_DEPTH-1:0] window);
      int ones;
      ones = 0;
      for (int k = 0; k < FILTER_DEPTH; k++) ones += int'(window[k]);
      return ones;
   endfunction

`ifdef QUADRATURE_INDEX_EN
   assign w_raw = {i_encZ, i_encB, i_encA};
`else
   assign w_raw = {i_encB, i_encA};
`endif

   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_hist  <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         for (int l = 0; l < NUM_LINES; l++)
            r_hist[l] <= {r_hist[l][HIST_DEPTH-2:0], r_sync2[l]};
      end
   end

   // The newest synchronized sample is part of the window, so the majority settles
   // FILTER_DEPTH/2 cycles after it first appears.
   always_comb begin
      w_filt = '0;
      for (int l = 0; l < NUM_LINES; l++)
         w_filt[l] = countOnes({r_hist[l], r_sync2[l]}) > FILTER_DEPTH / 2;
   end

   assign w_currBA   = w_filt[1:0];
   assign w_warmDone = (r_warmCount == WARM_LAST);
   assign w_step     = w_warmDone ? decodeTransition(r_prevBA, w_currBA) : STEP_NONE;

   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         r_warmCount <= '0;
         r_prevBA    <= '0;
         r_stepInc   <= 1'b0;
         r_stepDec   <= 1'b0;
      end else begin
         if (!w_warmDone) r_warmCount <= r_warmCount + WARM_ONE;
         r_prevBA  <= w_currBA;
         r_stepInc <= (w_step == STEP_INC) || (w_step == STEP_ERR);
         r_stepDec <= (w_step == STEP_DEC) || (w_step == STEP_ERR);
      end
   end

   assign w_isErr = r_stepInc & r_stepDec;
   assign w_isInc = r_stepInc & ~r_stepDec;
   assign w_isDec = r_stepDec & ~r_stepInc;

   // Counters consume the registered pulses; illegal transitions only touch the error count.
   always_comb begin
      w_accNext = r_acc;
      w_posNext = r_position;
      w_errNext = r_errAcc;
      if (w_isInc) begin
         w_posNext = r_position + ONE;
         if (r_acc != SAT_MAX) w_accNext = r_acc + ONE;
      end else if (w_isDec) begin
         w_posNext = r_position - ONE;
         if (r_acc != SAT_MIN) w_accNext = r_acc - ONE;
      end
      if (w_isErr && (r_errAcc != ERR_MAX)) w_errNext = r_errAcc + ERR_ONE;
   end

   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         r_position <= '0;
         r_acc      <= '0;
         r_delta    <= '0;
         r_errAcc   <= '0;
         r_errCount <= '0;
      end else begin
         r_position <= w_posNext;
         if (i_latch) begin
            r_delta    <= r_acc;
            r_errCount <= r_errAcc;
            r_acc      <= w_isInc ? ONE : (w_isDec ? MINUS_ONE : '0);
            r_errAcc   <= w_isErr ? ERR_ONE : '0;
         end else begin
            r_acc    <= w_accNext;
            r_errAcc <= w_errNext;
         end
      end
   end

`ifdef QUADRATURE_INDEX_EN
   logic                  r_prevZ;
   logic                  w_zRise;
   logic                  r_indexFlag;
   logic [DATA_WIDTH-1:0] r_indexPosition;

   assign w_zRise = w_warmDone & w_filt[2] & ~r_prevZ;

   // A Z edge wins over a same-cycle latch so the flag is never lost.
   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         r_prevZ         <= 1'b0;
         r_indexFlag     <= 1'b0;
         r_indexPosition <= '0;
      end else begin
         r_prevZ <= w_filt[2];
         if (w_zRise) begin
            r_indexPosition <= w_posNext;
            r_indexFlag     <= 1'b1;
         end else if (i_latch) begin
            r_indexFlag <= 1'b0;
         end
      end
   end

   assign o_indexPosition = r_indexPosition;
   assign o_indexFlag     = r_indexFlag;
`else
   logic w_unusedZ;
   assign w_unusedZ       = i_encZ;
   assign o_indexPosition = '0;
   assign o_indexFlag     = 1'b0;
`endif

   assign o_stepInc    = r_stepInc;
   assign o_stepDec    = r_stepDec;
   assign o_delta      = r_delta;
   assign o_errorCount = r_errCount;
   assign o_position   = r_position;

endmodule

// File: rtl/quadrature_decoder_array.sv
// quadrature_decoder_array: CHANNELS independent quadrature decoders sharing one latch strobe.
// Index capture is built only when QUADRATURE_INDEX_EN is defined.
module quadrature_decoder_array
   import quadrature_pkg::*;
#(
   parameter int                  CHANNELS     = 4,
   parameter int                  DATA_WIDTH   = 16,
   parameter int                  FILTER_DEPTH = 3,
   parameter logic [CHANNELS-1:0] INVERSE_MASK = '0
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic                                  latch,
   input  logic [CHANNELS-1:0]                   enc_a,
   input  logic [CHANNELS-1:0]                   enc_b,
   input  logic [CHANNELS-1:0]                   enc_z,
   output logic [CHANNELS-1:0]                   step_inc,
   output logic [CHANNELS-1:0]                   step_dec,
   output logic [CHANNELS*DATA_WIDTH-1:0]        delta,
   output logic [CHANNELS*ERROR_COUNT_WIDTH-1:0] error_count,
   output logic                                  latch_valid,
   output logic [CHANNELS*DATA_WIDTH-1:0]        position,
   output logic [CHANNELS*DATA_WIDTH-1:0]        index_position,
   output logic [CHANNELS-1:0]                   index_flag
);

   logic r_latchValid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_latchValid <= 1'b0;
      else          r_latchValid <= latch;
   end

   assign latch_valid = r_latchValid;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_channel
      logic w_chanA;
      logic w_chanB;

      // Swapping A and B reverses the counting direction of a miswired encoder.
      assign w_chanA = INVERSE_MASK[c] ? enc_b[c] : enc_a[c];
      assign w_chanB = INVERSE_MASK[c] ? enc_a[c] : enc_b[c];

      quadrature_channel #(
         .DATA_WIDTH   (DATA_WIDTH),
         .FILTER_DEPTH (FILTER_DEPTH)
      ) u_channel (
         .i_clk           (clk),
         .i_rstN          (reset_n),
         .i_latch         (latch),
         .i_encA          (w_chanA),
         .i_encB          (w_chanB),
         .i_encZ          (enc_z[c]),
         .o_stepInc       (step_inc[c]),
         .o_stepDec       (step_dec[c]),
         .o_delta         (delta[c*DATA_WIDTH +: DATA_WIDTH]),
         .o_errorCount    (error_count[c*ERROR_COUNT_WIDTH +: ERROR_COUNT_WIDTH]),
         .o_position      (position[c*DATA_WIDTH +: DATA_WIDTH]),
         .o_indexPosition (index_position[c*DATA_WIDTH +: DATA_WIDTH]),
         .o_indexFlag     (index_flag[c])
      );
   end

endmodule

// File: tb/tb_quadrature_decoder_array.sv
// tb_quadrature_decoder_array: directed checks of the decoder array with an 8-bit datapath,
// channel 3 A/B swapped; index checks follow QUADRATURE_INDEX_EN.
module tb_quadrature_decoder_array;

   localparam int CH = 4;
   localparam int DW = 8;
   localparam int FD = 3;

   logic              clk     = 1'b0;
   logic              reset_n = 1'b1;
   logic              latch   = 1'b0;
   logic [CH-1:0]     enc_a   = '0;
   logic [CH-1:0]     enc_b   = '0;
   logic [CH-1:0]     enc_z   = '0;
   logic [CH-1:0]     step_inc;
   logic [CH-1:0]     step_dec;
   logic [CH*DW-1:0]  delta;
   logic [CH*8-1:0]   error_count;
   logic              latch_valid;
   logic [CH*DW-1:0]  position;
   logic [CH*DW-1:0]  index_position;
   logic [CH-1:0]     index_flag;

   int         testsRun    = 0;
   int         testsFailed = 0;
   int         incSeen[CH];
   int         decSeen[CH];
   int         errSeen[CH];
   logic [1:0] encState[CH];
   int         snapInc;
   int         snapDec;
   int         snapErr;

   quadrature_decoder_array #(
      .CHANNELS     (CH),
      .DATA_WIDTH   (DW),
      .FILTER_DEPTH (FD),
      .INVERSE_MASK (4'b1000)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .latch          (latch),
      .enc_a          (enc_a),
      .enc_b          (enc_b),
      .enc_z          (enc_z),
      .step_inc       (step_inc),
      .step_dec       (step_dec),
      .delta          (delta),
      .error_count    (error_count),
      .latch_valid    (latch_valid),
      .position       (position),
      .index_position (index_position),
      .index_flag     (index_flag)
   );

   always #5 clk = ~clk;

   // Pulse observer sampled on the falling edge, away from register updates.
   always @(negedge clk) begin
      for (int c = 0; c < CH; c++) begin
         if (step_inc[c] && step_dec[c]) errSeen[c]++;
         else if (step_inc[c])           incSeen[c]++;
         else if (step_dec[c])           decSeen[c]++;
      end
   end

   function automatic logic [DW-1:0] deltaOf(input int ch);
      return delta[ch*DW +: DW];
   endfunction

   function automatic logic [DW-1:0] posOf(input int ch);
      return position[ch*DW +: DW];
   endfunction

   function automatic logic [7:0] errOf(input int ch);
      return error_count[ch*8 +: 8];
   endfunction

   function automatic logic [1:0] nextFwd(input logic [1:0] ba);
      case (ba)
         2'b00:   return 2'b01;
         2'b01:   return 2'b11;
         2'b11:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] nextRev(input logic [1:0] ba);
      case (ba)
         2'b00:   return 2'b10;
         2'b10:   return 2'b11;
         2'b11:   return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
      end
   endtask

   task automatic applyStimulus(input int ch, input logic [1:0] ba, input int hold);
      enc_a[ch]    = ba[0];
      enc_b[ch]    = ba[1];
      encState[ch] = ba;
      waitCycles(hold);
   endtask

   task automatic moveSteps(input int ch, input int n, input bit forward);
      for (int i = 0; i < n; i++)
         applyStimulus(ch, forward ? nextFwd(encState[ch]) : nextRev(encState[ch]), 3);
   endtask

   task automatic doLatch(input string tag);
      latch = 1'b1;
      waitCycles(1);
      latch = 1'b0;
      checkOutput({tag, "_latch_valid"}, 32'(latch_valid), 32'd1);
   endtask

   initial begin
      for (int c = 0; c < CH; c++) encState[c] = 2'b00;

      #2 reset_n = 1'b0;
      waitCycles(3);
      checkOutput("rst_latch_valid", 32'(latch_valid), 32'd0);
      checkOutput("rst_step_inc", 32'(step_inc), 32'd0);
      checkOutput("rst_step_dec", 32'(step_dec), 32'd0);
      checkOutput("rst_position", position, 32'd0);
      checkOutput("rst_delta", delta, 32'd0);
      checkOutput("rst_error_count", error_count, 32'd0);
      checkOutput("rst_index_flag", 32'(index_flag), 32'd0);
      reset_n = 1'b1;
      waitCycles(10);

      // Channel 0: ten clean forward cycles = 40 steps.
      snapInc = incSeen[0];
      moveSteps(0, 40, 1'b1);
      waitCycles(8);
      checkOutput("fwd_inc_pulses", 32'(incSeen[0] - snapInc), 32'd40);
      checkOutput("fwd_position0", 32'(posOf(0)), 32'd40);
      doLatch("fwd");
      checkOutput("fwd_delta0", 32'(deltaOf(0)), 32'd40);
      checkOutput("fwd_error0", 32'(errOf(0)), 32'd0);
      checkOutput("fwd_delta1", 32'(deltaOf(1)), 32'd0);
      waitCycles(1);
      checkOutput("fwd_latch_valid_drop", 32'(latch_valid), 32'd0);

      // Channel 1: single-cycle glitch on A must be filtered out.
      snapInc = incSeen[1];
      snapDec = decSeen[1];
      snapErr = errSeen[1];
      enc_a[1] = 1'b1;
      waitCycles(1);
      enc_a[1] = 1'b0;
      waitCycles(10);
      checkOutput("glitch_pulses", 32'((incSeen[1] - snapInc) + (decSeen[1] - snapDec) + (errSeen[1] - snapErr)), 32'd0);
      doLatch("glitch");
      checkOutput("glitch_delta1", 32'(deltaOf(1)), 32'd0);
      checkOutput("glitch_position1", 32'(posOf(1)), 32'd0);

      // Channel 2: 200 reverse steps saturate delta but position wraps.
      snapDec = decSeen[2];
      moveSteps(2, 200, 1'b0);
      waitCycles(8);
      checkOutput("sat_dec_pulses", 32'(decSeen[2] - snapDec), 32'd200);
      doLatch("sat");
      checkOutput("sat_delta2", 32'(deltaOf(2)), 32'h80);
      checkOutput("sat_position2", 32'(posOf(2)), 32'd56);
      checkOutput("sat_delta0_idle", 32'(deltaOf(0)), 32'd0);

      // Channel 1: A and B toggled together three times.
      snapInc = incSeen[1];
      snapDec = decSeen[1];
      snapErr = errSeen[1];
      applyStimulus(1, 2'b11, 3);
      applyStimulus(1, 2'b00, 3);
      applyStimulus(1, 2'b11, 3);
      waitCycles(8);
      checkOutput("err_both_pulses", 32'(errSeen[1] - snapErr), 32'd3);
      checkOutput("err_single_pulses", 32'((incSeen[1] - snapInc) + (decSeen[1] - snapDec)), 32'd0);
      doLatch("err");
      checkOutput("err_count1", 32'(errOf(1)), 32'd3);
      checkOutput("err_delta1", 32'(deltaOf(1)), 32'd0);
      checkOutput("err_position1", 32'(posOf(1)), 32'd0);

      // Channel 0: accumulate 5, then latch in the cycle the sixth step pulse is visible.
      moveSteps(0, 5, 1'b1);
      waitCycles(8);
      enc_b[0]    = 1'b1;
      encState[0] = 2'b11;
      waitCycles(3);
      checkOutput("lat_step_early", 32'(step_inc[0]), 32'd0);
      waitCycles(1);
      checkOutput("lat_step_on_time", 32'(step_inc[0]), 32'd1);
      doLatch("coinc");
      checkOutput("coinc_delta0", 32'(deltaOf(0)), 32'd5);
      waitCycles(5);
      doLatch("coinc_next");
      checkOutput("coinc_next_delta0", 32'(deltaOf(0)), 32'd1);
      checkOutput("coinc_position0", 32'(posOf(0)), 32'd46);

      // Channel 3 has A/B swapped: a raw forward cycle counts down.
      snapDec = decSeen[3];
      moveSteps(3, 4, 1'b1);
      waitCycles(8);
      checkOutput("inv_dec_pulses", 32'(decSeen[3] - snapDec), 32'd4);
      doLatch("inv");
      checkOutput("inv_delta3", 32'(deltaOf(3)), 32'hFC);
      checkOutput("inv_position3", 32'(posOf(3)), 32'd252);

      // Channel 0: move to position 123, then raise Z.
      moveSteps(0, 77, 1'b1);
      waitCycles(8);
      checkOutput("idx_position0", 32'(posOf(0)), 32'd123);
      enc_z[0] = 1'b1;
      waitCycles(8);
`ifdef QUADRATURE_INDEX_EN
      checkOutput("idx_flag0_set", 32'(index_flag), 32'd1);
      checkOutput("idx_capture0", 32'(index_position[DW-1:0]), 32'd123);
      waitCycles(5);
      checkOutput("idx_flag0_sticky", 32'(index_flag[0]), 32'd1);
      doLatch("idx");
      checkOutput("idx_flag0_cleared", 32'(index_flag[0]), 32'd0);
      checkOutput("idx_capture0_held", 32'(index_position[DW-1:0]), 32'd123);
`else
      checkOutput("idx_flag_off", 32'(index_flag), 32'd0);
      checkOutput("idx_position_off", index_position, 32'd0);
      doLatch("idx");
`endif
      checkOutput("idx_delta0", 32'(deltaOf(0)), 32'd77);

      // Reset mid-accumulation, released with channel 0 at 01 and channel 1 at 11.
      moveSteps(0, 2, 1'b1);
      waitCycles(2);
      reset_n = 1'b0;
      #2;
      checkOutput("mid_rst_position", position, 32'd0);
      checkOutput("mid_rst_delta", delta, 32'd0);
      checkOutput("mid_rst_error_count", error_count, 32'd0);
      checkOutput("mid_rst_steps", 32'({step_inc, step_dec}), 32'd0);
      checkOutput("mid_rst_index", 32'(index_flag), 32'd0);
      checkOutput("mid_rst_index_pos", index_position, 32'd0);
      waitCycles(2);
      snapInc = incSeen[0] + incSeen[1];
      snapDec = decSeen[0] + decSeen[1];
      snapErr = errSeen[0] + errSeen[1];
      reset_n = 1'b1;
      waitCycles(15);
      checkOutput("warm_no_steps", 32'((incSeen[0] + incSeen[1] - snapInc) + (decSeen[0] + decSeen[1] - snapDec)), 32'd0);
      checkOutput("warm_no_errors", 32'(errSeen[0] + errSeen[1] - snapErr), 32'd0);
      checkOutput("warm_position", position, 32'd0);
      checkOutput("warm_index_flag", 32'(index_flag), 32'd0);
      doLatch("warm");
      checkOutput("warm_delta", delta, 32'd0);
      checkOutput("warm_error_count", error_count, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
